// File: rtl/br_resolve_ctrl.sv
// Branch resolution controller: per-tag checkpoints captured at dispatch, judged at execute,
// producing registered correct/recovery pulses with restore mask and redirect PC.
module br_resolve_ctrl #(
    parameter int BR_MASK_W = 5,
    parameter int PC_W      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_br_alloc_i,
    input  logic [BR_MASK_W-1:0] id_br_tag_i,
    input  logic [BR_MASK_W-1:0] id_br_mask_i,
    input  logic                 id_br_pred_taken_i,
    input  logic [PC_W-1:0]      id_br_pred_target_i,
    input  logic [PC_W-1:0]      id_br_npc_i,
    input  logic                 ex_br_valid_i,
    input  logic [BR_MASK_W-1:0] ex_br_tag_i,
    input  logic                 ex_br_taken_i,
    input  logic [PC_W-1:0]      ex_br_target_i,
    output logic                 br_pred_correct_o,
    output logic                 br_recovery_o,
    output logic [BR_MASK_W-1:0] br_tag_o,
    output logic [BR_MASK_W-1:0] br_mask_o,
    output logic [PC_W-1:0]      br_recovery_pc_o,
    output logic [BR_MASK_W-1:0] ckpt_valid_o,
    output logic                 br_err_o
);

    logic [BR_MASK_W-1:0]                ckpt_valid_q, ckpt_valid_d;
    logic [BR_MASK_W-1:0][BR_MASK_W-1:0] ckpt_mask_q, ckpt_mask_d;
    logic [BR_MASK_W-1:0]                pred_taken_q, pred_taken_d;
    logic [BR_MASK_W-1:0][PC_W-1:0]      pred_target_q, pred_target_d;
    logic [BR_MASK_W-1:0][PC_W-1:0]      npc_q, npc_d;

    logic                 correct_q, recovery_q, err_q;
    logic [BR_MASK_W-1:0] tag_q, mask_q;
    logic [PC_W-1:0]      pc_q;

    logic                 ex_onehot, id_onehot, res_hit, correct, do_correct, do_mispred;
    logic                 alloc_ok, proto_err;
    logic [BR_MASK_W-1:0] sel_mask, younger, clr_bit;
    logic                 sel_pt;
    logic [PC_W-1:0]      sel_tgt, sel_npc;

    always_comb begin
        ex_onehot = $onehot(ex_br_tag_i);
        id_onehot = $onehot(id_br_tag_i);
        sel_mask  = '0;
        sel_pt    = 1'b0;
        sel_tgt   = '0;
        sel_npc   = '0;
        younger   = '0;
        for (int i = 0; i < BR_MASK_W; i++) begin
            if (ex_br_tag_i[i]) begin
                sel_mask = ckpt_mask_q[i];
                sel_pt   = pred_taken_q[i];
                sel_tgt  = pred_target_q[i];
                sel_npc  = npc_q[i];
            end
            younger[i] = ckpt_valid_q[i] && |(ckpt_mask_q[i] & ex_br_tag_i);
        end

        // Stale resolutions (entry already squashed/freed) fall out here silently.
        res_hit    = ex_br_valid_i && ex_onehot && |(ex_br_tag_i & ckpt_valid_q);
        correct    = (ex_br_taken_i == sel_pt) && (!ex_br_taken_i || ex_br_target_i == sel_tgt);
        do_correct = res_hit && correct;
        do_mispred = res_hit && !correct;
        clr_bit    = do_correct ? ex_br_tag_i : '0;

        // A branch dispatched alongside a misprediction is younger, so it is dropped.
        alloc_ok  = id_br_alloc_i && id_onehot && !do_mispred;
        proto_err = (ex_br_valid_i && !ex_onehot) || (id_br_alloc_i && !id_onehot) ||
                    (alloc_ok && |(id_br_tag_i & ckpt_valid_q & ~clr_bit));

        ckpt_valid_d  = ckpt_valid_q & ~clr_bit;
        ckpt_mask_d   = ckpt_mask_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        npc_d         = npc_q;
        if (do_mispred)
            ckpt_valid_d = ckpt_valid_q & ~(ex_br_tag_i | younger);
        for (int i = 0; i < BR_MASK_W; i++) begin
            ckpt_mask_d[i] = ckpt_mask_q[i] & ~clr_bit;
            if (alloc_ok && id_br_tag_i[i]) begin
                ckpt_valid_d[i]  = 1'b1;
                ckpt_mask_d[i]   = id_br_mask_i & ~clr_bit;
                pred_taken_d[i]  = id_br_pred_taken_i;
                pred_target_d[i] = id_br_pred_target_i;
                npc_d[i]         = id_br_npc_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ckpt_valid_q  <= '0;
            ckpt_mask_q   <= '0;
            pred_taken_q  <= '0;
            pred_target_q <= '0;
            npc_q         <= '0;
            correct_q     <= 1'b0;
            recovery_q    <= 1'b0;
            tag_q         <= '0;
            mask_q        <= '0;
            pc_q          <= '0;
            err_q         <= 1'b0;
        end else begin
            ckpt_valid_q  <= ckpt_valid_d;
            ckpt_mask_q   <= ckpt_mask_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            npc_q         <= npc_d;
            correct_q     <= do_correct;
            recovery_q    <= do_mispred;
            tag_q         <= res_hit ? ex_br_tag_i : '0;
            mask_q        <= do_mispred ? sel_mask : '0;
            pc_q          <= do_mispred ? (ex_br_taken_i ? ex_br_target_i : sel_npc) : '0;
            err_q         <= err_q | proto_err;
        end
    end

    assign br_pred_correct_o = correct_q;
    assign br_recovery_o     = recovery_q;
    assign br_tag_o          = tag_q;
    assign br_mask_o         = mask_q;
    assign br_recovery_pc_o  = pc_q;
    assign ckpt_valid_o      = ckpt_valid_q;
    assign br_err_o          = err_q;

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Bench for br_resolve_ctrl: directed scenarios plus randomized traffic against a
// tag-indexed behavioural model of the checkpoint table.
module tb_br_resolve_ctrl;
    localparam int W = 5;
    localparam int P = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         id_br_alloc_i, id_br_pred_taken_i, ex_br_valid_i, ex_br_taken_i;
    logic [W-1:0] id_br_tag_i, id_br_mask_i, ex_br_tag_i;
    logic [P-1:0] id_br_pred_target_i, id_br_npc_i, ex_br_target_i;
    logic         br_pred_correct_o, br_recovery_o, br_err_o;
    logic [W-1:0] br_tag_o, br_mask_o, ckpt_valid_o;
    logic [P-1:0] br_recovery_pc_o;

    br_resolve_ctrl #(.BR_MASK_W(W), .PC_W(P)) dut (
        .clk(clk), .rst(rst),
        .id_br_alloc_i(id_br_alloc_i), .id_br_tag_i(id_br_tag_i), .id_br_mask_i(id_br_mask_i),
        .id_br_pred_taken_i(id_br_pred_taken_i), .id_br_pred_target_i(id_br_pred_target_i),
        .id_br_npc_i(id_br_npc_i),
        .ex_br_valid_i(ex_br_valid_i), .ex_br_tag_i(ex_br_tag_i), .ex_br_taken_i(ex_br_taken_i),
        .ex_br_target_i(ex_br_target_i),
        .br_pred_correct_o(br_pred_correct_o), .br_recovery_o(br_recovery_o), .br_tag_o(br_tag_o),
        .br_mask_o(br_mask_o), .br_recovery_pc_o(br_recovery_pc_o), .ckpt_valid_o(ckpt_valid_o),
        .br_err_o(br_err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: a table indexed by tag number.
    logic         m_valid[W];
    logic [W-1:0] m_mask[W];
    logic         m_pt[W];
    logic [P-1:0] m_tgt[W], m_npc[W];
    logic         e_corr, e_rec, e_err;
    logic [W-1:0] e_tag, e_mask;
    logic [P-1:0] e_pc;

    wire [81:0] dut_out = {br_pred_correct_o, br_recovery_o, br_tag_o, br_mask_o,
                           br_recovery_pc_o, ckpt_valid_o, br_err_o};

    function automatic logic [W-1:0] m_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [81:0] exp_out();
        return {e_corr, e_rec, e_tag, e_mask, e_pc, m_vec(), e_err};
    endfunction

    function automatic int idx_of(logic [W-1:0] t);
        if ($countones(t) != 1) return -1;
        for (int i = 0; i < W; i++) if (t[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        int  k, a;
        bit  corr, mis;
        e_corr = 0; e_rec = 0; e_tag = '0; e_mask = '0; e_pc = '0;
        corr = 0; mis = 0;
        if (rst) begin
            for (int i = 0; i < W; i++) begin
                m_valid[i] = 0; m_mask[i] = '0; m_pt[i] = 0; m_tgt[i] = '0; m_npc[i] = '0;
            end
            e_err = 0;
            return;
        end
        k = idx_of(ex_br_tag_i);
        a = idx_of(id_br_tag_i);
        if (ex_br_valid_i && k < 0) e_err = 1;
        if (id_br_alloc_i && a < 0) e_err = 1;
        if (ex_br_valid_i && k >= 0 && m_valid[k]) begin
            e_tag = ex_br_tag_i;
            if (ex_br_taken_i == m_pt[k] && (!ex_br_taken_i || ex_br_target_i == m_tgt[k])) begin
                corr = 1; e_corr = 1;
                m_valid[k] = 0;
                for (int j = 0; j < W; j++) m_mask[j][k] = 1'b0;
            end else begin
                mis = 1; e_rec = 1;
                e_mask = m_mask[k];
                e_pc = ex_br_taken_i ? ex_br_target_i : m_npc[k];
                m_valid[k] = 0;
                for (int j = 0; j < W; j++) if (m_mask[j][k]) m_valid[j] = 0;
            end
        end
        if (id_br_alloc_i && a >= 0 && !mis) begin
            if (m_valid[a]) e_err = 1;
            m_valid[a] = 1;
            m_mask[a]  = id_br_mask_i;
            if (corr) m_mask[a][k] = 1'b0;
            m_pt[a]  = id_br_pred_taken_i;
            m_tgt[a] = id_br_pred_target_i;
            m_npc[a] = id_br_npc_i;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_br_alloc_i = 0; id_br_tag_i = '0; id_br_mask_i = '0; id_br_pred_taken_i = 0;
        id_br_pred_target_i = '0; id_br_npc_i = '0;
        ex_br_valid_i = 0; ex_br_tag_i = '0; ex_br_taken_i = 0; ex_br_target_i = '0;
    endtask

    task automatic alloc(input logic [W-1:0] t, input logic [W-1:0] m, input logic pt,
                         input logic [P-1:0] tg, input logic [P-1:0] np);
        id_br_alloc_i = 1; id_br_tag_i = t; id_br_mask_i = m; id_br_pred_taken_i = pt;
        id_br_pred_target_i = tg; id_br_npc_i = np;
    endtask

    task automatic resolve(input logic [W-1:0] t, input logic tk, input logic [P-1:0] tg);
        ex_br_valid_i = 1; ex_br_tag_i = t; ex_br_taken_i = tk; ex_br_target_i = tg;
    endtask

    task automatic do_reset();
        idle(); rst = 1; cycle(); cycle(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_out !== 82'd0 || dut_out !== exp_out()) begin
            n_fail++; $display("FAIL reset: got %h want %h", dut_out, 82'd0);
        end
    endtask

    task automatic test_correct();
        do_reset();
        alloc(5'b00001, 5'b00000, 1, 64'h100, 64'h104); cycle(); idle();
        resolve(5'b00001, 1, 64'h100); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || !br_pred_correct_o || br_recovery_o ||
            br_tag_o !== 5'b00001 || ckpt_valid_o !== 5'b00000) begin
            n_fail++; $display("FAIL correct: got %h want %h", dut_out, exp_out());
        end
        cycle();
        n_cmp++;
        if (br_pred_correct_o !== 1'b0 || dut_out !== exp_out()) begin
            n_fail++; $display("FAIL correct_pulse_width: got %h want %h", dut_out, exp_out());
        end
    endtask

    task automatic test_mispredict_nt();
        do_reset();
        alloc(5'b00001, 5'b00000, 1, 64'h100, 64'h104); cycle();
        alloc(5'b00010, 5'b00001, 1, 64'h200, 64'h204); cycle();
        alloc(5'b00100, 5'b00011, 1, 64'h300, 64'h304); cycle(); idle();
        resolve(5'b00010, 0, 64'h0); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || !br_recovery_o || br_pred_correct_o ||
            br_mask_o !== 5'b00001 || br_recovery_pc_o !== 64'h204 || ckpt_valid_o !== 5'b00001) begin
            n_fail++; $display("FAIL mispredict_nt: got %h want %h", dut_out, exp_out());
        end
    endtask

    task automatic test_retire_then_mispredict();
        do_reset();
        alloc(5'b00001, 5'b00000, 0, 64'h100, 64'h104); cycle();
        alloc(5'b00010, 5'b00001, 0, 64'h200, 64'h208); cycle(); idle();
        resolve(5'b00001, 0, 64'h0); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || !br_pred_correct_o || ckpt_valid_o !== 5'b00010) begin
            n_fail++; $display("FAIL retire_first: got %h want %h", dut_out, exp_out());
        end
        resolve(5'b00010, 1, 64'h300); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || !br_recovery_o || br_mask_o !== 5'b00000 ||
            br_recovery_pc_o !== 64'h300 || br_tag_o !== 5'b00010) begin
            n_fail++; $display("FAIL mispredict_taken: got %h want %h", dut_out, exp_out());
        end
    endtask

    task automatic test_alloc_during_recovery();
        do_reset();
        alloc(5'b00001, 5'b00000, 0, 64'h100, 64'h104); cycle(); idle();
        resolve(5'b00001, 1, 64'h400);
        alloc(5'b00100, 5'b00001, 0, 64'h500, 64'h504); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || !br_recovery_o || ckpt_valid_o !== 5'b00000 ||
            br_recovery_pc_o !== 64'h400) begin
            n_fail++; $display("FAIL alloc_squashed: got %h want %h", dut_out, exp_out());
        end
        resolve(5'b00100, 0, 64'h0); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || br_pred_correct_o || br_recovery_o || br_err_o) begin
            n_fail++; $display("FAIL stale_resolve: got %h want %h", dut_out, exp_out());
        end
    endtask

    task automatic test_tag_forwarding();
        do_reset();
        for (int i = 0; i < W; i++) begin
            alloc(5'b1 << i, (5'b1 << i) - 5'b1, 0, 64'h600, 64'h604 + 64'(i)); cycle();
        end
        idle();
        resolve(5'b00001, 0, 64'h0);
        alloc(5'b00001, 5'b11111, 0, 64'h700, 64'h704); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || !br_pred_correct_o || ckpt_valid_o !== 5'b11111 || br_err_o) begin
            n_fail++; $display("FAIL tag_forward: got %h want %h", dut_out, exp_out());
        end
        // The restored mask of the re-allocated entry exposes the cleared own-tag bit.
        resolve(5'b00001, 1, 64'h800); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || br_mask_o !== 5'b11110 || ckpt_valid_o !== 5'b11110 ||
            br_recovery_pc_o !== 64'h800) begin
            n_fail++; $display("FAIL forward_mask: got %h want %h", dut_out, exp_out());
        end
    endtask

    task automatic test_bad_tag();
        do_reset();
        alloc(5'b00001, 5'b00000, 0, 64'h100, 64'h104); cycle(); idle();
        resolve(5'b00011, 0, 64'h0); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || br_pred_correct_o || br_recovery_o || !br_err_o ||
            ckpt_valid_o !== 5'b00001) begin
            n_fail++; $display("FAIL bad_tag: got %h want %h", dut_out, exp_out());
        end
        repeat (3) cycle();
        n_cmp++;
        if (br_err_o !== 1'b1 || dut_out !== exp_out()) begin
            n_fail++; $display("FAIL err_sticky: got %b want 1", br_err_o);
        end
        do_reset();
        n_cmp++;
        if (br_err_o !== 1'b0 || dut_out !== exp_out()) begin
            n_fail++; $display("FAIL err_clear: got %b want 0", br_err_o);
        end
    endtask

    task automatic test_double_alloc();
        do_reset();
        alloc(5'b01000, 5'b00000, 0, 64'h100, 64'h104); cycle();
        alloc(5'b01000, 5'b00000, 1, 64'h900, 64'h904); cycle(); idle();
        n_cmp++;
        if (dut_out !== exp_out() || !br_err_o || ckpt_valid_o !== 5'b01000) begin
            n_fail++; $display("FAIL double_alloc: got %h want %h", dut_out, exp_out());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc(5'b00001, 5'b00000, 0, 64'h100, 64'h104); cycle(); idle();
        resolve(5'b00001, 1, 64'h200); rst = 1; cycle(); rst = 0; idle();
        n_cmp++;
        if (dut_out !== 82'd0 || dut_out !== exp_out()) begin
            n_fail++; $display("FAIL reset_mid: got %h want %h", dut_out, 82'd0);
        end
    endtask

    task automatic test_random();
        logic [P-1:0] pcs[4];
        pcs[0] = 64'h1000; pcs[1] = 64'h2000; pcs[2] = 64'h3000; pcs[3] = 64'h4000;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 1)
                alloc(($urandom_range(0, 39) == 0) ? 5'($urandom) : (5'b1 << $urandom_range(0, W-1)),
                      5'($urandom), 1'($urandom), pcs[$urandom_range(0, 3)], 64'($urandom));
            if ($urandom_range(0, 9) < 6)
                resolve(($urandom_range(0, 39) == 0) ? 5'($urandom) : (5'b1 << $urandom_range(0, W-1)),
                        1'($urandom), pcs[$urandom_range(0, 3)]);
            cycle();
            n_cmp++;
            if (dut_out !== exp_out() || (br_pred_correct_o && br_recovery_o)) begin
                n_fail++; $display("FAIL random c=%0d: got %h want %h", c, dut_out, exp_out());
            end
            if (br_err_o && $urandom_range(0, 3) == 0) begin
                rst = 1;
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle();
        e_err = 0;
        test_reset();
        test_correct();
        test_mispredict_nt();
        test_retire_then_mispredict();
        test_alloc_during_recovery();
        test_tag_forwarding();
        test_bad_tag();
        test_double_alloc();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/br_resolve_ctrl.md
Name: br_resolve_ctrl

Overview:
- Resolution-side partner of the branch mask generator.
- Holds one checkpoint per branch tag, captured when a speculative branch is dispatched.
- Judges execute-stage branch outcomes against the stored prediction and drives the correct-prediction / recovery pulse, one-hot tag, restore mask and redirect PC that the mask generator and ROB consume.
- Sits between the branch FU writeback and the mask generator / ROB.

Parameters:
BR_MASK_W, 5, number of branch tags and width of every mask/tag bus
PC_W, 64, width of PCs and targets

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_br_alloc_i  in  1  speculative branch dispatched this cycle
id_br_tag_i  in  BR_MASK_W  one-hot tag assigned to that branch
id_br_mask_i  in  BR_MASK_W  mask in force before this branch (restore value)
id_br_pred_taken_i  in  1  predicted direction
id_br_pred_target_i  in  PC_W  predicted target
id_br_npc_i  in  PC_W  fall-through PC
ex_br_valid_i  in  1  branch outcome valid
ex_br_tag_i  in  BR_MASK_W  one-hot tag of resolving branch
ex_br_taken_i  in  1  actual direction
ex_br_target_i  in  PC_W  actual target
br_pred_correct_o  out  1  one-cycle pulse: tag retires correctly
br_recovery_o  out  1  one-cycle pulse: misprediction, squash
br_tag_o  out  BR_MASK_W  one-hot tag being resolved
br_mask_o  out  BR_MASK_W  mask to restore (valid with recovery)
br_recovery_pc_o  out  PC_W  redirect PC (valid with recovery)
ckpt_valid_o  out  BR_MASK_W  live checkpoint vector
br_err_o  out  1  sticky protocol error

Behaviour:
- State: per tag i, ckpt_valid[i], ckpt_mask[i], pred_taken[i], pred_target[i], npc[i].
- Reset: all state and all outputs are 0; br_err_o clears.

Allocation:
- On id_br_alloc_i, the entry selected by id_br_tag_i captures the dispatch fields and sets valid at the next edge.
- If that entry is already valid, the write still happens and br_err_o sets.

Resolution:
- ex_br_valid_i in cycle N with a valid entry is evaluated combinationally.
- correct = (taken == pred_taken) && (!taken || target == pred_target).
- Outputs are registered and asserted in cycle N+1 for exactly one cycle.
- br_tag_o = ex_br_tag_i.
- If the entry is invalid (already squashed or freed), the resolution is dropped silently with no pulse and no error.
- A non-one-hot ex_br_tag_i or id_br_tag_i sets br_err_o and is ignored.

Correct prediction:
- Clear ckpt_valid[tag].
- Clear that tag bit in ckpt_mask of every other entry, so later restores never resurrect a retired tag.
- br_mask_o = 0, br_recovery_pc_o = 0.

Misprediction:
- br_mask_o = ckpt_mask[tag] after the same-cycle clearing.
- br_recovery_pc_o = taken ? ex_br_target_i : npc[tag].
- Invalidate the entry itself and every valid entry j with ckpt_mask[j] & tag != 0 (the younger branches).
- Allocation in the same cycle as a misprediction is discarded, since the dispatching branch is younger.

Simultaneous events:
- Allocation plus correct resolution in the same cycle: both apply.
- The new entry's mask has the resolved tag bit cleared before storage.
- If alloc tag equals the resolved tag, the new allocation wins with no error (tag forwarding by the mask generator).

Other rules:
- br_pred_correct_o and br_recovery_o are mutually exclusive.
- Throughput: one resolution per cycle, no stall.
- rst asserted mid-operation drops all checkpoints and suppresses any pending output pulse.

Test Plan:
1. Reset, then alloc tag 00001 (mask 00000, pred taken, target 0x100); resolve taken 0x100 -> cycle N+1: br_pred_correct_o=1, br_tag_o=00001, ckpt_valid_o=00000.
2. Alloc tags 00001 (mask 00000), 00010 (mask 00001), 00100 (mask 00011); mispredict 00010 not-taken with npc 0x204 -> br_recovery_o=1, br_mask_o=00001, br_recovery_pc_o=0x204, ckpt_valid_o=00001.
3. Alloc 00001, then 00010 (mask 00001); correct-resolve 00001, then mispredict 00010 taken to 0x300 -> br_mask_o=00000, br_recovery_pc_o=0x300.
4. Mispredict 00001 while alloc 00100 in the same cycle -> recovery pulse; 00100 never becomes valid; a later resolve of 00100 produces no pulse.
5. All five tags live; correct-resolve 00001 while allocating 00001 with mask 11111 -> entry 00001 valid with mask 11110, br_err_o=0.
6. ex_br_tag_i=00011 -> no pulse, br_err_o=1 until reset.
